data_ram_ctrl: RTL and testbench

Wait-state data memory responder for the Sirius core: the memory-side end of the core's load/store port. It accepts one request at a time from the core's MEM stage, inserts a configurable number of wait states, and performs a byte-masked write or a full-word read. It signals completion with a one-cycle `ready_o` pulse. It sits in `cpu_top` beside `inst_rom`, on the data port rather than the instruction-fetch port.

---
 rtl/data_ram_ctrl_pkg.sv | 24 ++
 rtl/data_ram_ctrl_if.sv | 31 +++
 rtl/data_ram_ctrl_array.sv | 50 +++++
 rtl/data_ram_ctrl.sv | 130 +++++++++++++
 tb/tb_data_ram_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl_pkg
//   Shared bus-width macros for the Sirius data port and the constants used by
//   the data memory responder and its RAM array.
//   No ports (package + macro header).
// ---------------------------------------------------------------------------
`ifndef DATA_RAM_CTRL_DEFINES
`define DATA_RAM_CTRL_DEFINES
`define DataAddrBus 31:0
`define DataBus     31:0
`define ByteWidth   3:0
`define WriteEnable 1'b1
`define ReadEnable  1'b0
`define ChipEnable  1'b1
`endif

package data_ram_ctrl_pkg;
  // Wait-state counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;
  // Byte lanes per 32-bit word.
  localparam int LANES    = 4;
  localparam int LANE_W   = 8;
endpackage

// File: rtl/data_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl_if
//   Load/store port between the core MEM stage (master) and the data memory
//   responder (slave).
//   ce      : request valid, held until ready_o
//   we      : 1 = write, 0 = read
//   addr    : byte address
//   sel     : byte enables, sel[3] -> [31:24] ... sel[0] -> [7:0]
//   data_i  : write data
//   data_o  : registered read data
//   ready_o : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface data_ram_ctrl_if;
  logic                ce;
  logic                we;
  logic [`DataAddrBus] addr;
  logic [`ByteWidth]   sel;
  logic [`DataBus]     data_i;
  logic [`DataBus]     data_o;
  logic                ready_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, ready_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, ready_o
  );
endinterface

// File: rtl/data_ram_ctrl_array.sv
// ---------------------------------------------------------------------------
// data_ram_array
//   Single-port synchronous RAM, 32-bit words, per-byte write mask and a
//   registered read port. The read register only loads on a read access, so
//   it holds the last read word between reads.
//   clk   : clock
//   rst   : synchronous active-high reset (clears read register, blocks write)
//   en    : access strobe
//   we    : 1 = write, 0 = read
//   addr  : word address
//   sel   : byte-lane write mask
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [`ByteWidth]     sel,
  input  logic [`DataBus]       wdata,
  output logic [`DataBus]       rdata
);

  logic [`DataBus] mem [0:(1<<DEPTH_LOG2)-1];

  // Memory contents are intentionally left unreset. Reset still blocks a
  // write that lands on the same edge.
  always_ff @(posedge clk) begin
    if (en && (we == `WriteEnable) && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && (we == `ReadEnable)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl
//   Wait-state data memory responder on the Sirius core data port. Accepts one
//   request at a time, waits WAIT_CYCLES cycles, then performs a byte-masked
//   write or a full-word read and pulses ready_o for one cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : data_ram_ctrl_if slave (ce, we, addr, sel, data_i, data_o, ready_o)
// ---------------------------------------------------------------------------
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;

  // Request latches, loaded when a request is accepted in IDLE.
  logic                    req_we;
  logic [DEPTH_LOG2-1:0]   req_word;
  logic [`ByteWidth]       req_sel;
  logic [`DataBus]         req_wdata;
  logic                    req_take;

  // Access presented to the array on the edge that enters ACCESS.
  logic                    acc_en;
  logic                    acc_we;
  logic [DEPTH_LOG2-1:0]   acc_word;
  logic [`ByteWidth]       acc_sel;
  logic [`DataBus]         acc_wdata;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (req_take) begin
      req_we    <= bus.we;
      req_word  <= bus.addr[DEPTH_LOG2+1:2];
      req_sel   <= bus.sel;
      req_wdata <= bus.data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_take  = 1'b0;
    acc_en    = 1'b0;
    acc_we    = req_we;
    acc_word  = req_word;
    acc_sel   = req_sel;
    acc_wdata = req_wdata;
    case (state)
      S_IDLE: begin
        if (bus.ce == `ChipEnable) begin
          req_take = 1'b1;
          cnt_nxt  = WAIT_INIT;
          if (WAIT_INIT == '0) begin
            // Zero wait states: the acceptance edge is also the access edge,
            // so the live request bypasses the latches.
            state_nxt = S_ACCESS;
            acc_en    = 1'b1;
            acc_we    = bus.we;
            acc_word  = bus.addr[DEPTH_LOG2+1:2];
            acc_sel   = bus.sel;
            acc_wdata = bus.data_i;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (bus.ce != `ChipEnable) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = S_ACCESS;
          acc_en    = 1'b1;
        end
      end
      S_ACCESS: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ready_o = (state == S_ACCESS);

  data_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_en),
    .we    (acc_we),
    .addr  (acc_word),
    .sel   (acc_sel),
    .wdata (acc_wdata),
    .rdata (bus.data_o)
  );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
//   Three responders (WAIT_CYCLES = 0, 1, 3) on one clock, driven through
//   table vectors, hand-written multi-cycle sequences and random traffic,
//   all compared against a word-array reference model.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;

  logic clk = 1'b0;
  logic rst0, rst1, rst3;
  always #5 clk = ~clk;

  data_ram_ctrl_if if0 ();
  data_ram_ctrl_if if1 ();
  data_ram_ctrl_if if3 ();

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

  int checks   = 0;
  int failures = 0;

  // Index 0/1/2 selects the responder with 0/1/3 wait states.
  int          wc [3] = '{0, 1, 3};
  logic [31:0] mdl_mem  [3][1024];
  logic [31:0] mdl_dout [3];

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] w);
    case (d)
      0: begin if0.ce = ce; if0.we = we; if0.addr = a; if0.sel = s; if0.data_i = w; end
      1: begin if1.ce = ce; if1.we = we; if1.addr = a; if1.sel = s; if1.data_i = w; end
      default: begin if3.ce = ce; if3.we = we; if3.addr = a; if3.sel = s; if3.data_i = w; end
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0: return if0.ready_o;
      1: return if1.ready_o;
      default: return if3.ready_o;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int d);
    case (d)
      0: return if0.data_o;
      1: return if1.data_o;
      default: return if3.data_o;
    endcase
  endfunction

  // One complete request, starting and ending just after a falling edge.
  // With garble set, the request inputs are scrambled during the wait states.
  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] w, input bit garble, output logic [31:0] dout);
    int lat;
    int idx;
    lat  = -1;
    dout = '0;
    drive(d, 1'b1, we, a, s, w);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_rdy(d)) begin
        lat  = k;
        dout = get_dout(d);
        break;
      end
      if (garble) drive(d, 1'b1, 1'($urandom), $urandom, 4'($urandom), $urandom);
    end
    drive(d, 1'b0, 1'b0, '0, '0, '0);
    check($sformatf("latency[d%0d]", d), lat, wc[d] + 1);
    // Reference: the addressed word is (byte address / 4) mod 1024.
    idx = int'((a / 4) % 1024);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl_mem[d][idx][8*b +: 8] = w[8*b +: 8];
    end else begin
      mdl_dout[d] = mdl_mem[d][idx];
    end
    check($sformatf("data_o[d%0d a=%h we=%0d]", d, a, we), dout, mdl_dout[d]);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("ready_single[d%0d]", d), 32'(get_rdy(d)), 32'd0);
  endtask

  logic [31:0] got;
  int          seen;
  int          pool [3][8];

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 1'b0, '0, '0, '0);
      mdl_dout[d] = '0;
    end

    vecs[0]  = '{1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1]  = '{1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1, 1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{1, 1'b1, 32'h0000_0020, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF};
    vecs[4]  = '{1, 1'b0, 32'h0000_0020, 4'hF, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{1, 1'b1, 32'h0000_0020, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD};
    vecs[6]  = '{1, 1'b0, 32'h0000_0023, 4'h0, 32'h0,        32'h11BB33DD};
    vecs[7]  = '{0, 1'b1, 32'h0000_1000, 4'hF, 32'h12345678, 32'h0000_0000};
    vecs[8]  = '{0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,        32'h12345678};
    vecs[9]  = '{0, 1'b0, 32'hFFFF_F002, 4'h3, 32'h0,        32'h12345678};
    vecs[10] = '{2, 1'b1, 32'h0000_0030, 4'hF, 32'h01020304, 32'h0000_0000};
    vecs[11] = '{2, 1'b0, 32'h0000_0030, 4'h0, 32'h0,        32'h01020304};

    // Reset for two cycles, then check the idle outputs.
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready[d%0d]", d), 32'(get_rdy(d)), 32'd0);
      check($sformatf("reset_data[d%0d]", d), get_dout(d), 32'h0);
    end

    // Table vectors; the first one is issued on the first cycle out of reset.
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, 1'b0, got);
      check($sformatf("vec%0d", i), got, vecs[i].exp_data);
    end

    // Abort: 3 wait states, ce dropped during the second wait cycle.
    drive(2, 1'b1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    drive(2, 1'b0, 1'b0, '0, '0, '0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (get_rdy(2)) seen++;
    end
    check("abort_no_ready", seen, 0);
    txn(2, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, got);
    check("abort_old_value", got, 32'h01020304);

    // Reset landing on the edge that would enter ACCESS for a write.
    txn(1, 1'b1, 32'h40, 4'hF, 32'h5555AAAA, 1'b0, got);
    txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, got);
    drive(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    @(posedge clk); @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstmid_ready", 32'(get_rdy(1)), 32'd0);
    check("rstmid_data", get_dout(1), 32'h0);
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    mdl_dout[1] = '0;
    @(posedge clk); @(negedge clk);
    check("rstmid_idle_ready", 32'(get_rdy(1)), 32'd0);
    txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, got);
    check("rstmid_mem_kept", got, 32'h5555AAAA);

    // Random traffic over a pre-initialised pool of words per responder,
    // with random high/low address bits and scrambled inputs during waits.
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 8; p++) begin
        pool[d][p] = int'($urandom_range(0, 1023));
        txn(d, 1'b1, 32'(pool[d][p] * 4), 4'hF, $urandom, 1'b0, got);
      end
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        a = {20'($urandom), 10'(pool[d][$urandom_range(0, 7)]), 2'($urandom)};
        txn(d, 1'($urandom), a, 4'($urandom), $urandom, 1'b1, got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
